uart_tx_sched: RTL and testbench

Round-robin frame scheduler that shares one `uart_tx` serializer between `N_CH` byte-stream requesters. It grants one requester for a whole frame and wraps the payload as HEADER, ID, payload…, XOR checksum. It issues each byte to `uart_tx` as a single-cycle `tx_req` and waits for that byte's `tx_done` before issuing the next. It sits between the acquisition/report blocks and the `uart_tx` instance that drives the board TX pin.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rr_pick.sv | 37 +++
 rtl/uart_tx_sched.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: scheduler state encoding,
// default frame header / ID base, and the baud divider constant that the
// uart_tx serializer uses.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HDR       = 3'd1,
    ST_ID        = 3'd2,
    ST_DATA      = 3'd3,
    ST_CSUM      = 3'd4,
    ST_CSUM_WAIT = 3'd5
  } sched_state_t;

  localparam logic [7:0] HEADER_DEF  = 8'hA5;
  localparam logic [7:0] ID_BASE_DEF = 8'h10;

  localparam int unsigned SYS_CLK_HZ      = 50_000_000;
  localparam int unsigned BAUD_RATE       = 115_200;
  localparam int unsigned MAX_CNT_SYS_CLK = SYS_CLK_HZ / BAUD_RATE - 1;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: searches req starting one position after
// `last`, wrapping around, and returns the first requester found.
// Ports:
//   req  - request vector, one bit per channel
//   last - index of the most recently served channel
//   gnt  - one-hot winner (all zero when no request)
//   idx  - binary index of the winner
//   any  - at least one request is present
module uart_rr_pick #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned IDXW = 2
) (
  input  logic [N_CH-1:0] req,
  input  logic [IDXW-1:0] last,
  output logic [N_CH-1:0] gnt,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  logic [IDXW-1:0] pos;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      pos = IDXW'((32'(last) + i) % N_CH);
      if (!any && req[pos]) begin
        any      = 1'b1;
        idx      = pos;
        gnt[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin frame scheduler sharing one uart_tx between N_CH byte streams.
// A granted channel owns a whole frame: HEADER, ID_BASE+idx, payload bytes,
// then the XOR checksum of ID and payload. Each byte is a single-cycle tx_req;
// the next byte is only issued once the previous byte's tx_done has arrived.
// Ports:
//   sys_clk, sys_rst_n        - clock, asynchronous active-low reset
//   ch_valid/ch_data/ch_last  - per-channel byte streams (channel k at [8k+7:8k])
//   ch_ready                  - one-hot byte accept toward the granted channel
//   tx_req/tx_data/tx_done    - byte handshake with uart_tx
//   grant, busy               - frame owner and frame-in-progress
//   frame_done, frame_err     - end-of-frame pulse, forced-close pulse
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned N_CH          = 4,
  parameter logic [7:0]  HEADER        = HEADER_DEF,
  parameter logic [7:0]  ID_BASE       = ID_BASE_DEF,
  parameter int unsigned MAX_LEN       = 16,
  parameter logic [15:0] STALL_TIMEOUT = 16'd50000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [N_CH-1:0]   ch_valid,
  input  logic [8*N_CH-1:0] ch_data,
  input  logic [N_CH-1:0]   ch_last,
  output logic [N_CH-1:0]   ch_ready,
  output logic              tx_req,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic [N_CH-1:0]   grant,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int unsigned IDXW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned LENW = $clog2(MAX_LEN + 1);

  sched_state_t    state;
  logic [IDXW-1:0] idx;
  logic [IDXW-1:0] last;
  logic [IDXW-1:0] pick_idx;
  logic [N_CH-1:0] pick_gnt;
  logic            pick_any;
  logic [7:0]      csum;
  logic [LENW-1:0] len;
  logic [15:0]     stall_cnt;
  logic            wait_done;
  logic            err_flag;

  logic            uart_free;
  logic            cur_valid;
  logic            cur_last;
  logic [7:0]      cur_data;
  logic [7:0]      id_byte;
  logic            accept;

  uart_rr_pick #(
    .N_CH (N_CH),
    .IDXW (IDXW)
  ) u_pick (
    .req  (ch_valid),
    .last (last),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // tx_done counts as "free" in its own cycle so the next byte goes out with
  // no idle slot; wait_done is cleared by the same edge.
  assign uart_free = !wait_done || tx_done;

  always_comb begin
    cur_valid = ch_valid[idx];
    cur_last  = ch_last[idx];
    cur_data  = ch_data[{idx, 3'b000} +: 8];
    id_byte   = ID_BASE + 8'(idx);
    accept    = (state == ST_DATA) && uart_free && cur_valid;
    ch_ready  = accept ? grant : '0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      last       <= IDXW'(N_CH - 1);
      csum       <= '0;
      len        <= '0;
      stall_cnt  <= '0;
      wait_done  <= 1'b0;
      err_flag   <= 1'b0;
      tx_req     <= 1'b0;
      tx_data    <= '0;
      grant      <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      tx_req     <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (tx_done) wait_done <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant     <= pick_gnt;
            idx       <= pick_idx;
            busy      <= 1'b1;
            csum      <= '0;
            len       <= '0;
            stall_cnt <= '0;
            err_flag  <= 1'b0;
            state     <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (uart_free) begin
            tx_req    <= 1'b1;
            tx_data   <= HEADER;
            wait_done <= 1'b1;
            state     <= ST_ID;
          end
        end
        ST_ID: begin
          if (uart_free) begin
            tx_req    <= 1'b1;
            tx_data   <= id_byte;
            wait_done <= 1'b1;
            csum      <= csum ^ id_byte;
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (accept) begin
            tx_req    <= 1'b1;
            tx_data   <= cur_data;
            wait_done <= 1'b1;
            csum      <= csum ^ cur_data;
            len       <= len + 1'b1;
            stall_cnt <= '0;
            if (cur_last) begin
              state <= ST_CSUM;
            end else if (len == LENW'(MAX_LEN - 1)) begin
              state    <= ST_CSUM;
              err_flag <= 1'b1;
            end
          end else if (uart_free) begin
            // Stall time only accrues while the UART is idle and the owner has nothing.
            if (stall_cnt == STALL_TIMEOUT - 16'd1) begin
              state    <= ST_CSUM;
              err_flag <= 1'b1;
            end else begin
              stall_cnt <= stall_cnt + 16'd1;
            end
          end
        end
        ST_CSUM: begin
          if (uart_free) begin
            tx_req    <= 1'b1;
            tx_data   <= csum;
            wait_done <= 1'b1;
            state     <= ST_CSUM_WAIT;
          end
        end
        ST_CSUM_WAIT: begin
          if (tx_done) begin
            frame_done <= 1'b1;
            frame_err  <= err_flag;
            last       <= idx;
            grant      <= '0;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
`timescale 1ns/1ps
module tb_uart_tx_sched;

  localparam int N = 4;

  logic           sys_clk = 1'b0;
  logic           sys_rst_n = 1'b0;
  logic [N-1:0]   ch_valid;
  logic [8*N-1:0] ch_data;
  logic [N-1:0]   ch_last;
  logic [N-1:0]   ch_ready;
  logic           tx_req;
  logic [7:0]     tx_data;
  logic           tx_done;
  logic [N-1:0]   grant;
  logic           busy;
  logic           frame_done;
  logic           frame_err;

  uart_tx_sched #(
    .N_CH          (N),
    .HEADER        (8'hA5),
    .ID_BASE       (8'h10),
    .MAX_LEN       (4),
    .STALL_TIMEOUT (16'd40)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .ch_valid   (ch_valid),
    .ch_data    (ch_data),
    .ch_last    (ch_last),
    .ch_ready   (ch_ready),
    .tx_req     (tx_req),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .grant      (grant),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  // kind: 0 header, 1 id, 2 payload, 3 checksum
  typedef struct { logic [7:0] data; int kind; bit gap0; } exp_b_t;
  typedef struct { int idx; bit err; } exp_f_t;
  typedef logic [7:0] bq_t [$];

  exp_b_t     exp_b [$];
  exp_f_t     exp_f [$];
  logic [8:0] src_q [N][$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // uart_tx stand-in: tx_done pulses 3 cycles after each tx_req
  initial begin : uart_stub
    int cnt;
    cnt = 0;
    tx_done = 1'b0;
    forever begin
      @(posedge sys_clk);
      #2;
      tx_done = 1'b0;
      if (!sys_rst_n) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) tx_done = 1'b1;
        end
        if (tx_req) cnt = 3;
      end
    end
  end

  // per-channel byte sources fed from src_q
  initial begin : src_drv
    logic [N-1:0] acc;
    ch_valid = '0;
    ch_data  = '0;
    ch_last  = '0;
    forever begin
      @(negedge sys_clk);
      acc = ch_valid & ch_ready;
      @(posedge sys_clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        if (src_q[k].size() > 0) begin
          ch_valid[k]        = 1'b1;
          ch_data[8*k +: 8]  = src_q[k][0][7:0];
          ch_last[k]         = src_q[k][0][8];
        end else begin
          ch_valid[k]        = 1'b0;
          ch_data[8*k +: 8]  = 8'h00;
          ch_last[k]         = 1'b0;
        end
      end
    end
  end

  // monitor / scoreboard
  exp_b_t     m_e;
  exp_f_t     m_f;
  bit         outstanding;
  logic       prev_req, prev_done, prev_busy;
  logic [N-1:0] prev_ready, frame_grant;
  bit         grant_bad;
  int         busy_age;

  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      exp_b.delete();
      exp_f.delete();
      outstanding = 0;
      prev_req    = 1'b0;
      prev_done   = 1'b0;
      prev_busy   = 1'b0;
      prev_ready  = '0;
      frame_grant = '0;
      grant_bad   = 0;
      busy_age    = 0;
    end else begin
      if (busy) busy_age++; else busy_age = 0;
      if (busy && !prev_busy) begin
        frame_grant = grant;
        grant_bad   = ($countones(grant) != 1);
      end else if (busy && grant != frame_grant) begin
        grant_bad = 1;
      end

      if (tx_req) begin
        chk("tx_req_overlap", 32'(outstanding), 0);
        chk("tx_req_width", 32'(prev_req), 0);
        if (exp_b.size() == 0) begin
          chk("unexpected_tx_req", 32'(tx_req), 0);
        end else begin
          m_e = exp_b.pop_front();
          chk("tx_data", 32'(tx_data), 32'(m_e.data));
          if (m_e.kind == 0) chk("hdr_latency", busy_age, 2);
          if (m_e.kind == 2) chk("ready_before_req", 32'((prev_ready & frame_grant) != '0), 1);
          if (m_e.gap0) chk("zero_gap", 32'(prev_done), 1);
        end
        outstanding = 1;
      end
      if (tx_done) outstanding = 0;

      if (frame_done) begin
        if (exp_f.size() == 0) begin
          chk("unexpected_frame_done", 32'(frame_done), 0);
        end else begin
          m_f = exp_f.pop_front();
          chk("frame_grant", 32'(frame_grant), 32'(1) << m_f.idx);
          chk("frame_err", 32'(frame_err), 32'(m_f.err));
          chk("grant_onehot_held", 32'(grant_bad), 0);
        end
      end else if (frame_err) begin
        chk("frame_err_alone", 32'(frame_err), 32'(frame_done));
      end

      prev_req   = tx_req;
      prev_done  = tx_done;
      prev_busy  = busy;
      prev_ready = ch_ready;
    end
  end

  task automatic push_src(input int ch, input logic [7:0] d, input bit l);
    src_q[ch].push_back({l, d});
  endtask

  task automatic exp_frame(input int idx, input bq_t b, input bit err, input bit csum_gap0);
    exp_b_t e;
    exp_f_t f;
    for (int i = 0; i < b.size(); i++) begin
      e.data = b[i];
      e.kind = (i == 0) ? 0 : (i == 1) ? 1 : (i == b.size() - 1) ? 3 : 2;
      e.gap0 = (i == 0) ? 1'b0 : (i == b.size() - 1) ? csum_gap0 : 1'b1;
      exp_b.push_back(e);
    end
    f.idx = idx;
    f.err = err;
    exp_f.push_back(f);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c;
    c = 0;
    while ((exp_f.size() != 0 || exp_b.size() != 0 || busy) && c < budget) begin
      @(posedge sys_clk);
      c++;
    end
    #3;
    chk({name, "_drain"}, 32'(exp_f.size() + exp_b.size()), 0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_tx_req"},     32'(tx_req), 0);
    chk({name, "_tx_data"},    32'(tx_data), 0);
    chk({name, "_grant"},      32'(grant), 0);
    chk({name, "_busy"},       32'(busy), 0);
    chk({name, "_frame_done"}, 32'(frame_done), 0);
    chk({name, "_frame_err"},  32'(frame_err), 0);
    chk({name, "_ch_ready"},   32'(ch_ready), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bq_t bq;
    int  c;

    sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #3;
    chk_all_zero("reset");

    // fairness from reset: ch0 and ch1 each queue two one-byte frames
    push_src(0, 8'hA0, 1'b1);
    push_src(0, 8'hA2, 1'b1);
    push_src(1, 8'hB1, 1'b1);
    push_src(1, 8'hB3, 1'b1);
    sys_rst_n = 1'b1;
    bq = '{8'hA5, 8'h10, 8'hA0, 8'hB0}; exp_frame(0, bq, 1'b0, 1'b1);
    bq = '{8'hA5, 8'h11, 8'hB1, 8'hA0}; exp_frame(1, bq, 1'b0, 1'b1);
    bq = '{8'hA5, 8'h10, 8'hA2, 8'hB2}; exp_frame(0, bq, 1'b0, 1'b1);
    bq = '{8'hA5, 8'h11, 8'hB3, 8'hA2}; exp_frame(1, bq, 1'b0, 1'b1);
    wait_drain("fair", 400);

    // single frame on ch1
    @(posedge sys_clk); #3;
    bq = '{8'hA5, 8'h11, 8'h12, 8'h34, 8'h37}; exp_frame(1, bq, 1'b0, 1'b1);
    push_src(1, 8'h12, 1'b0);
    push_src(1, 8'h34, 1'b1);
    wait_drain("single", 200);

    // stall timeout on ch3
    @(posedge sys_clk); #3;
    bq = '{8'hA5, 8'h13, 8'h55, 8'h46}; exp_frame(3, bq, 1'b1, 1'b0);
    push_src(3, 8'h55, 1'b0);
    wait_drain("stall", 300);

    // overflow at MAX_LEN=4; 0x05 opens the next frame, which then stalls
    @(posedge sys_clk); #3;
    bq = '{8'hA5, 8'h10, 8'h01, 8'h02, 8'h03, 8'h04, 8'h14}; exp_frame(0, bq, 1'b1, 1'b1);
    bq = '{8'hA5, 8'h10, 8'h05, 8'h15}; exp_frame(0, bq, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) push_src(0, 8'(i), 1'b0);
    wait_drain("overflow", 500);

    // reset in the middle of a ch2 payload
    @(posedge sys_clk); #3;
    bq = '{8'hA5, 8'h12, 8'h21, 8'h22, 8'h23, 8'h32}; exp_frame(2, bq, 1'b0, 1'b1);
    push_src(2, 8'h21, 1'b0);
    push_src(2, 8'h22, 1'b0);
    push_src(2, 8'h23, 1'b1);
    c = 0;
    while (!(tx_req && tx_data == 8'h21) && c < 100) begin
      @(negedge sys_clk);
      c++;
    end
    chk("rst_mid_grant", 32'(grant), 32'h4);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    for (int k = 0; k < N; k++) src_q[k].delete();
    repeat (3) @(negedge sys_clk);
    @(posedge sys_clk); #3;
    sys_rst_n = 1'b1;
    bq = '{8'hA5, 8'h10, 8'h0A, 8'h1A}; exp_frame(0, bq, 1'b0, 1'b1);
    bq = '{8'hA5, 8'h12, 8'h2B, 8'h39}; exp_frame(2, bq, 1'b0, 1'b1);
    push_src(0, 8'h0A, 1'b1);
    push_src(2, 8'h2B, 1'b1);
    wait_drain("after_rst", 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
